// File: rtl/ej32_mbus_arb.sv
// N-channel arbiter that serialises 1..DSZ/8-byte big-endian reads/writes onto the spram8 byte bus.
// One transfer at a time; grant is combinational in IDLE, completion is signalled by a one-cycle ack.
module ej32_mbus_arb #(
   parameter int NCH = 3,
   parameter int DSZ = 32,
   parameter int ASZ = 17,
   parameter int RR  = 0,
   localparam int SW = $clog2(DSZ/8) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NCH-1:0]     req,
   input  logic [NCH-1:0]     we,
   input  logic [NCH*SW-1:0]  sz,
   input  logic [NCH*ASZ-1:0] addr,
   input  logic [NCH*DSZ-1:0] wdata,
   output logic [NCH-1:0]     gnt,
   output logic [NCH-1:0]     ack,
   output logic [DSZ-1:0]     rdata,
   output logic               busy,
   output logic [ASZ-1:0]     mem_a,
   output logic               mem_we,
   output logic [7:0]         mem_vi,
   input  logic [7:0]         mem_vo
);

   localparam int NB = DSZ/8;
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

   state_t           state, state_nx;
   logic [PW-1:0]    ptr, win, wid;
   logic             any;
   logic             we_l;
   logic [SW-1:0]    nb, k;
   logic [DSZ-1:0]   wsh, rsh, rq;
   logic             cap;

   logic [SW-1:0]    sz_w, n_w;
   logic [ASZ-1:0]   addr_w;
   logic [DSZ-1:0]   wdata_w, wal;
   logic             we_w;
   logic             last;

   // Winner select: fixed scans from 0, round-robin scans from ptr with wrap.
   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      any = 1'b0;
      for (int j = 0; j < NCH; j++) begin
         idx = (RR != 0) ? ((int'(ptr) + j) % NCH) : j;
         if (!any && req[idx]) begin
            any = 1'b1;
            win = PW'(idx);
         end
      end
   end

   always_comb begin
      sz_w    = sz[int'(win)*SW +: SW];
      addr_w  = addr[int'(win)*ASZ +: ASZ];
      wdata_w = wdata[int'(win)*DSZ +: DSZ];
      we_w    = we[win];
      if (sz_w == '0)
         n_w = SW'(1);
      else if (sz_w > SW'(NB))
         n_w = SW'(NB);
      else
         n_w = sz_w;
      // Left-align the N significant bytes so bytes always leave from the top.
      wal = wdata_w << (DSZ - 8*int'(n_w));
   end

   assign last = (k == nb - 1'b1);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any) state_nx = XFER;
         XFER:    if (last) state_nx = we_l ? DONE : DRAIN;
         DRAIN:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign gnt    = (state == IDLE && any) ? (NCH'(1) << win) : '0;
   assign ack    = (state == DONE) ? (NCH'(1) << wid) : '0;
   assign busy   = (state != IDLE);
   assign mem_we = (state == XFER) && we_l;
   assign rdata  = (state == DONE && !we_l) ? rsh : rq;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= '0;
         wid    <= '0;
         we_l   <= 1'b0;
         nb     <= '0;
         k      <= '0;
         mem_a  <= '0;
         mem_vi <= '0;
         wsh    <= '0;
         rsh    <= '0;
         rq     <= '0;
         cap    <= 1'b0;
      end else begin
         state <= state_nx;
         // mem_vo answers the previous address cycle, so capture lags by one.
         cap   <= (state == XFER) && !we_l;
         if (cap)
            rsh <= DSZ'({rsh, mem_vo});
         case (state)
            IDLE: begin
               if (any) begin
                  wid   <= win;
                  we_l  <= we_w;
                  nb    <= n_w;
                  k     <= '0;
                  mem_a <= addr_w;
                  rsh   <= '0;
                  if (int'(win) == NCH - 1)
                     ptr <= '0;
                  else
                     ptr <= win + 1'b1;
                  if (we_w) begin
                     mem_vi <= wal[DSZ-1 -: 8];
                     wsh    <= wal << 8;
                  end
               end
            end
            XFER: begin
               if (!last) begin
                  k     <= k + 1'b1;
                  mem_a <= mem_a + 1'b1;
                  if (we_l) begin
                     mem_vi <= wsh[DSZ-1 -: 8];
                     wsh    <= wsh << 8;
                  end
               end
            end
            DONE: begin
               if (!we_l)
                  rq <= rsh;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ej32_mbus_arb.sv
// Directed bench for ej32_mbus_arb: fixed-priority instance on a byte memory model,
// plus a round-robin instance used only for grant ordering.
module tb_ej32_mbus_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0;
   logic [2:0]  we  = '0;
   logic [8:0]  sz  = '0;
   logic [50:0] addr = '0;
   logic [95:0] wdata = '0;
   logic [2:0]  gnt, ack;
   logic [31:0] rdata;
   logic        busy, mem_we;
   logic [16:0] mem_a;
   logic [7:0]  mem_vi, mem_vo;

   logic [2:0]  r_req = '0;
   logic [2:0]  r_we = 3'b111;
   logic [8:0]  r_sz = 9'b001_001_001;
   logic [50:0] r_addr = '0;
   logic [95:0] r_wdata = '0;
   logic [2:0]  r_gnt, r_ack;
   logic [31:0] r_rdata;
   logic        r_busy, r_mem_we;
   logic [16:0] r_mem_a;
   logic [7:0]  r_mem_vi;
   logic [7:0]  r_mem_vo = 8'h00;

   logic        tb_we = 1'b0;
   logic [16:0] tb_a = '0;
   logic [7:0]  tb_d = '0;
   logic [7:0]  mem [0:131071];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ej32_mbus_arb #(.NCH(3), .DSZ(32), .ASZ(17), .RR(0)) u_dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .sz(sz), .addr(addr), .wdata(wdata),
      .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
      .mem_a(mem_a), .mem_we(mem_we), .mem_vi(mem_vi), .mem_vo(mem_vo));

   ej32_mbus_arb #(.NCH(3), .DSZ(32), .ASZ(17), .RR(1)) u_rr (
      .clk(clk), .rst(rst), .req(r_req), .we(r_we), .sz(r_sz), .addr(r_addr), .wdata(r_wdata),
      .gnt(r_gnt), .ack(r_ack), .rdata(r_rdata), .busy(r_busy),
      .mem_a(r_mem_a), .mem_we(r_mem_we), .mem_vi(r_mem_vi), .mem_vo(r_mem_vo));

   always @(posedge clk) begin
      if (tb_we)
         mem[tb_a] <= tb_d;
      else if (mem_we)
         mem[mem_a] <= mem_vi;
      mem_vo <= mem[mem_a];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [16:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_a = a; tb_d = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // One complete transfer on channel ch; n is the hand-clamped byte count.
   task automatic run(input int ch, input logic w, input logic [2:0] s, input logic [16:0] a,
                      input logic [31:0] wd, input int n, input logic [31:0] exp_rd, input string tag);
      logic [16:0] ea;
      @(negedge clk);
      req = '0;
      req[ch] = 1'b1;
      we[ch] = w;
      sz[ch*3 +: 3] = s;
      addr[ch*17 +: 17] = a;
      wdata[ch*32 +: 32] = wd;
      #1 chk({tag, ".gnt"}, gnt, 64'(3'b001 << ch));
      @(negedge clk);
      req[ch] = 1'b0;
      for (int i = 0; i < n; i++) begin
         ea = a + 17'(i);
         chk({tag, ".mem_a"}, mem_a, ea);
         chk({tag, ".mem_we"}, mem_we, w);
         if (w) chk({tag, ".mem_vi"}, mem_vi, wd[(n-1-i)*8 +: 8]);
         @(negedge clk);
      end
      if (!w) begin
         chk({tag, ".drain_ack"}, ack, 0);
         @(negedge clk);
      end
      chk({tag, ".ack"}, ack, 64'(3'b001 << ch));
      if (!w) chk({tag, ".rdata"}, rdata, exp_rd);
      @(negedge clk);
      chk({tag, ".ack_end"}, ack, 0);
      chk({tag, ".busy_end"}, busy, 0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.gnt", gnt, 0);
      chk("rst.ack", ack, 0);
      chk("rst.busy", busy, 0);
      chk("rst.mem_we", mem_we, 0);
      chk("rst.mem_a", mem_a, 0);
      chk("rst.mem_vi", mem_vi, 0);
      chk("rst.rdata", rdata, 0);
      rst = 1'b0;

      poke(17'h00100, 8'hDE); poke(17'h00101, 8'hAD);
      poke(17'h00102, 8'hBE); poke(17'h00103, 8'hEF);
      poke(17'h1FFFE, 8'h11); poke(17'h1FFFF, 8'h22);
      poke(17'h00000, 8'h33); poke(17'h00001, 8'h44);

      // 1. word read, ack at T+6
      run(1, 1'b0, 3'd4, 17'h00100, 32'h0, 4, 32'hDEADBEEF, "t1");

      // 2. halfword write, readbacks; rdata untouched by the write
      run(0, 1'b1, 3'd2, 17'h01000, 32'h0000_1234, 2, 32'h0, "t2w");
      chk("t2w.rdata_held", rdata, 32'hDEADBEEF);
      run(0, 1'b0, 3'd2, 17'h01000, 32'h0, 2, 32'h0000_1234, "t2r2");
      run(0, 1'b0, 3'd1, 17'h01001, 32'h0, 1, 32'h0000_0034, "t2r1");

      // 4. address wrap and size clamp
      run(2, 1'b0, 3'd4, 17'h1FFFE, 32'h0, 4, 32'h11223344, "t4wrap");
      run(2, 1'b0, 3'd0, 17'h00100, 32'h0, 1, 32'h000000DE, "t4sz0");
      run(2, 1'b0, 3'd7, 17'h00100, 32'h0, 4, 32'hDEADBEEF, "t4sz7");

      // 3a. fixed priority, each request dropped after its ack
      @(negedge clk);
      we = 3'b000;
      sz = 9'b001_001_001;
      addr = {17'h00102, 17'h00101, 17'h00100};
      req = 3'b111;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t3f.gnt", gnt, 64'(3'b001 << i));
         repeat (3) @(negedge clk);
         chk("t3f.ack", ack, 64'(3'b001 << i));
         chk("t3f.gnt_in_done", gnt, 0);
         @(negedge clk);
         req[i] = 1'b0;
      end
      #1 chk("t3f.gnt_none", gnt, 0);

      // 3b. round-robin with all requests held: 0,1,2,0
      @(negedge clk);
      r_req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t3rr.gnt", r_gnt, 64'(3'b001 << (i % 3)));
         repeat (3) @(negedge clk);
      end
      r_req = 3'b000;

      // 5. reset during the second byte of a write
      @(negedge clk);
      req = 3'b001; we = 3'b001; sz[2:0] = 3'd4; addr[16:0] = 17'h02000;
      wdata[31:0] = 32'hAABBCCDD;
      #1 chk("t5.gnt", gnt, 64'b001);
      @(negedge clk);
      req = 3'b000;
      chk("t5.we_b0", mem_we, 1);
      @(negedge clk);
      chk("t5.vi_b1", mem_vi, 8'hBB);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5.mem_we", mem_we, 0);
      chk("t5.busy", busy, 0);
      chk("t5.ack", ack, 0);
      repeat (3) begin
         @(negedge clk);
         chk("t5.no_ack", ack, 0);
      end
      run(2, 1'b0, 3'd1, 17'h00100, 32'h0, 1, 32'h000000DE, "t5b");

      // 6. ch1 drops req after grant; ch0 arrives mid-transfer
      @(negedge clk);
      req = 3'b010; we = 3'b000;
      sz = {3'd1, 3'd2, 3'd1};
      addr = {17'h0, 17'h00100, 17'h00103};
      #1 chk("t6.gnt1", gnt, 64'b010);
      @(negedge clk);
      req = 3'b001;
      #1 chk("t6.wait_x0", gnt, 0);
      @(negedge clk);
      chk("t6.wait_x1", gnt, 0);
      @(negedge clk);
      chk("t6.wait_drain", gnt, 0);
      @(negedge clk);
      chk("t6.ack1", ack, 64'b010);
      chk("t6.rdata1", rdata, 32'h0000DEAD);
      chk("t6.no_gnt_done", gnt, 0);
      @(negedge clk);
      chk("t6.gnt0", gnt, 64'b001);
      @(negedge clk);
      req = 3'b000;
      repeat (2) @(negedge clk);
      chk("t6.ack0", ack, 64'b001);
      chk("t6.rdata0", rdata, 32'h000000EF);
      @(negedge clk);
      chk("t6.rdata_held", rdata, 32'h000000EF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
